// File: rtl/serial_adder_unit.sv
// serial_adder_unit
// Bit-serial add/subtract stage. One full-adder evaluation per clock, LSB
// first, with a single carry flop between cycles. Sum bits enter the result
// register at the MSB end so that after WIDTH cycles the word is aligned.
// sum/cout/overflow are architectural outputs: they only change on the edge
// that completes an operation (or on reset) and hold through IDLE.

module serial_adder_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // Counter must index 0..WIDTH-1; keep at least one bit for WIDTH = 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ov_r;

    logic             bit_sum_s;
    logic             bit_carry_s;
    logic [WIDTH:0]   res_ext_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_bit_s;

    // Single-bit full adder cell: sum output.
    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    // Single-bit full adder cell: carry output (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Evaluate the current bit and pre-compute the shifted result word.
    always_comb begin
        bit_sum_s   = fa_sum(a_r[0], b_r[0], c_r);
        bit_carry_s = fa_carry(a_r[0], b_r[0], c_r);
        // Widen by one bit so the right shift is also legal when WIDTH = 1.
        res_ext_s   = {bit_sum_s, res_r};
        res_next_s  = res_ext_s[WIDTH:1];
        last_bit_s  = (cnt_r == LAST_IDX);
    end

    // Control FSM plus operand/carry/result datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ov_r    <= 1'b0;
        end else begin
            case (state_r)
                // DONE lasts exactly one cycle and returns to IDLE on the next
                // edge; a start present on that edge is taken immediately so
                // that back-to-back issue needs no bubble cycle.
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        // Subtraction is a + ~b + 1: invert B, force carry-in.
                        b_r     <= sub ? ~b : b;
                        c_r     <= sub ? 1'b1 : cin;
                        cnt_r   <= {CW{1'b0}};
                        res_r   <= {WIDTH{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> 1'b1;
                    b_r   <= b_r >> 1'b1;
                    c_r   <= bit_carry_s;
                    res_r <= res_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        // c_r still holds the carry into the MSB at this point.
                        sum_r   <= res_next_s;
                        cout_r  <= bit_carry_s;
                        ov_r    <= c_r ^ bit_carry_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = ov_r;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Testbench for serial_adder_unit: three instances (WIDTH 1, 8, 32) share the
// clock, reset and operand buses; each has its own start. Expected results
// come from a plain-arithmetic model of two's-complement add/subtract.

module tb_serial_adder_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        sub_i;
    logic        cin_i;
    logic [2:0]  start_w;

    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  cout_v;
    logic [2:0]  ov_v;
    logic        sum1;
    logic [7:0]  sum8;
    logic [31:0] sum32;
    logic [31:0] sum_v [3];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [33:0] last_res [3];

    assign sum_v[0] = {31'd0, sum1};
    assign sum_v[1] = {24'd0, sum8};
    assign sum_v[2] = sum32;

    always #5 clk = ~clk;

    serial_adder_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .sub(sub_i), .cin(cin_i),
        .a(a_i[0:0]), .b(b_i[0:0]), .busy(busy_v[0]), .done(done_v[0]),
        .sum(sum1), .cout(cout_v[0]), .overflow(ov_v[0])
    );

    serial_adder_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .sub(sub_i), .cin(cin_i),
        .a(a_i[7:0]), .b(b_i[7:0]), .busy(busy_v[1]), .done(done_v[1]),
        .sum(sum8), .cout(cout_v[1]), .overflow(ov_v[1])
    );

    serial_adder_unit #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start_w[2]), .sub(sub_i), .cin(cin_i),
        .a(a_i), .b(b_i), .busy(busy_v[2]), .done(done_v[2]),
        .sum(sum32), .cout(cout_v[2]), .overflow(ov_v[2])
    );

    function automatic int width_of(input int sel);
        return (sel == 0) ? 1 : ((sel == 1) ? 8 : 32);
    endfunction

    // Observed {overflow, cout, sum} of instance sel.
    function automatic logic [33:0] obs(input int sel);
        return {ov_v[sel], cout_v[sel], sum_v[sel]};
    endfunction

    // Reference: {overflow, cout, sum} of a +/- b on w bits.
    function automatic logic [33:0] model(input int w, input logic [31:0] ta,
                                          input logic [31:0] tb, input logic ts,
                                          input logic tc);
        logic [63:0] mask;
        logic [63:0] av;
        logic [63:0] bv;
        logic [63:0] tot;
        logic [63:0] s;
        logic        c;
        logic        co;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        av   = {32'd0, ta} & mask;
        bv   = ts ? (~{32'd0, tb} & mask) : ({32'd0, tb} & mask);
        c    = ts ? 1'b1 : tc;
        tot  = av + bv + {63'd0, c};
        s    = tot & mask;
        co   = tot[w];
        // Signed overflow: same-sign operands give a result of the other sign.
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
        return {ov, co, s[31:0]};
    endfunction

    // One operation on instance sel; p1/p2 = edges at which a stray start is driven.
    task automatic do_op(input int sel, input logic [31:0] ta, input logic [31:0] tb,
                         input logic ts, input logic tc, input int p1, input int p2,
                         input string nm);
        int          w;
        logic [33:0] exp_res;
        logic [33:0] want;
        w       = width_of(sel);
        exp_res = model(w, ta, tb, ts, tc);
        @(negedge clk);
        a_i = ta; b_i = tb; sub_i = ts; cin_i = tc;
        start_w[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_w[sel] = 1'b0;
        a_i   = $urandom;
        b_i   = $urandom;
        sub_i = 1'($urandom);
        cin_i = 1'($urandom);
        for (int k = 0; k <= w + 1; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy_v[sel] !== 1'(k < w)) begin
                n_fail++;
                $display("FAIL %s busy k=%0d got %b exp %b", nm, k, busy_v[sel], 1'(k < w));
            end
            n_checks++;
            if (done_v[sel] !== 1'(k == w)) begin
                n_fail++;
                $display("FAIL %s done k=%0d got %b exp %b", nm, k, done_v[sel], 1'(k == w));
            end
            want = (k < w) ? last_res[sel] : exp_res;
            n_checks++;
            if (obs(sel) !== want) begin
                n_fail++;
                $display("FAIL %s result k=%0d got ov/cout/sum %h exp %h", nm, k, obs(sel), want);
            end
            start_w[sel] = 1'((k + 1 == p1) || (k + 1 == p2));
        end
        start_w[sel] = 1'b0;
        last_res[sel] = exp_res;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_w = 3'b000; a_i = 32'd0; b_i = 32'd0; sub_i = 1'b0; cin_i = 1'b0;
        for (int s = 0; s < 3; s++) last_res[s] = 34'd0;
        #12;
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (obs(s) !== 34'd0 || busy_v[s] !== 1'b0 || done_v[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset sel=%0d got res %h busy %b done %b exp all 0",
                         s, obs(s), busy_v[s], done_v[s]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_w1_truth();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            do_op(0, {31'd0, v[2]}, {31'd0, v[1]}, 1'b0, v[0], 0, 0, "w1_truth");
        end
    endtask

    task automatic test_w8_directed();
        do_op(1, 32'h7F, 32'h01, 1'b0, 1'b0, 0, 0, "w8_7f_plus_1");
        do_op(1, 32'hFF, 32'h00, 1'b0, 1'b1, 0, 0, "w8_ff_plus_cin");
        do_op(1, 32'h05, 32'h07, 1'b1, 1'b0, 0, 0, "w8_sub_5_7");
        do_op(1, 32'h80, 32'h01, 1'b1, 1'b1, 3, 8, "w8_sub_80_1_stray_start");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            do_op(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, 0, "w8_rand");
        for (int i = 0; i < 4; i++)
            do_op(2, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, 0, "w32_rand");
        for (int i = 0; i < 4; i++)
            do_op(0, $urandom, $urandom, 1'b1, 1'($urandom), 0, 0, "w1_rand_sub");
    endtask

    task automatic test_reset_mid();
        int seen_done;
        @(negedge clk);
        a_i = 32'hFFFF_FFFF; b_i = 32'h0000_0001; sub_i = 1'b0; cin_i = 1'b0;
        start_w[2] = 1'b1;
        @(posedge clk);
        #1;
        start_w[2] = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            last_res[s] = 34'd0;
            n_checks++;
            if (obs(s) !== 34'd0 || busy_v[s] !== 1'b0 || done_v[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid sel=%0d got res %h busy %b done %b exp all 0",
                         s, obs(s), busy_v[s], done_v[s]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_v[2] === 1'b1 || busy_v[2] === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done got %0d active cycles exp 0", seen_done);
        end
        do_op(2, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, 0, "w32_after_reset");
    endtask

    task automatic test_back_to_back();
        int          w;
        int          dones;
        logic [33:0] e1;
        logic [33:0] e2;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a2;
        logic [31:0] b2;
        logic        s1;
        logic        s2;
        w  = 8;
        a1 = $urandom; b1 = $urandom; s1 = 1'b0;
        a2 = $urandom; b2 = $urandom; s2 = 1'b1;
        e1 = model(w, a1, b1, s1, 1'b1);
        e2 = model(w, a2, b2, s2, 1'b0);
        dones = 0;
        @(negedge clk);
        a_i = a1; b_i = b1; sub_i = s1; cin_i = 1'b1;
        start_w[1] = 1'b1;
        @(posedge clk);
        #1;
        a_i = a2; b_i = b2; sub_i = s2; cin_i = 1'b0;
        for (int k = 0; k <= 2 * w + 3; k++) begin
            @(negedge clk);
            if (done_v[1] === 1'b1) dones++;
            n_checks++;
            if (done_v[1] !== 1'((k == w) || (k == 2 * w + 1))) begin
                n_fail++;
                $display("FAIL b2b done k=%0d got %b", k, done_v[1]);
            end
            n_checks++;
            if (busy_v[1] !== 1'((k < w) || (k >= w + 1 && k <= 2 * w))) begin
                n_fail++;
                $display("FAIL b2b busy k=%0d got %b", k, busy_v[1]);
            end
            if (k == w) begin
                n_checks++;
                if (obs(1) !== e1) begin
                    n_fail++;
                    $display("FAIL b2b first got %h exp %h", obs(1), e1);
                end
            end
            if (k == 2 * w + 1) begin
                n_checks++;
                if (obs(1) !== e2) begin
                    n_fail++;
                    $display("FAIL b2b second got %h exp %h", obs(1), e2);
                end
            end
            if (k == w + 1) start_w[1] = 1'b0;
        end
        last_res[1] = e2;
        n_checks++;
        if (dones != 2) begin
            n_fail++;
            $display("FAIL b2b done_count got %0d exp 2", dones);
        end
    endtask

    initial begin
        test_reset();
        test_w1_truth();
        test_w8_directed();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
